// File: rtl/logic_axi4_stream_packet_arbiter_pkg.sv
// Shared types and the round-robin pick function for the AXI4-Stream packet
// arbiter and its round-robin sub-module.
//   state_t  : arbiter FSM state (IDLE = free to pick, LOCKED = packet in flight)
//   rr_pick  : one-hot grant of the first set request at or above pointer, wrapping
package logic_axi4_stream_packet_arbiter_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  // rr_pick works on a fixed-width vector so it can live in a package;
  // callers zero-extend their request vector and slice the result.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0]   req,
    input logic [RR_IDX_W-1:0] pointer,
    input int                  n
  );
    logic [RR_MAX-1:0]   grant;
    logic                found;
    logic [RR_IDX_W-1:0] idx;
    int                  j;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        j = int'(pointer) + k;
        if (j >= n) j = j - n;
        idx = RR_IDX_W'(j);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/logic_round_robin_arbiter.sv
// Combinational round-robin pick: first set req bit from pointer upward,
// wrapping N-1 -> 0. Grant is one-hot or zero; idx is its binary index
// (0 when nothing is requested).
//   req     in  N   request vector
//   pointer in  IW  search start index (must be < N)
//   grant   out N   one-hot grant
//   idx     out IW  encoded grant index
module logic_round_robin_arbiter
  import logic_axi4_stream_packet_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [RR_MAX-1:0] pick;

  always_comb begin
    pick  = rr_pick(RR_MAX'(req), RR_IDX_W'(pointer), N);
    grant = pick[N-1:0];
    idx   = '0;
    // bits >= N are always zero; scanning the full width keeps the encoder simple
    for (int k = 0; k < RR_MAX; k++) begin
      if (pick[k]) idx = IW'(k);
    end
  end

endmodule

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Round-robin AXI4-Stream packet arbiter: shares one sink between INPUTS
// requesters, holding the grant for a whole packet, with a registered output.
//   aclk, areset          clock, synchronous active-high reset
//   rx_tvalid/tready/tlast per-requester handshake and end-of-packet
//   rx_tdata              requester i payload at [i*WIDTH +: WIDTH]
//   tx_tvalid/tready/tlast registered output handshake
//   tx_tdata              registered payload
//   tx_tid                source index of the current output beat
module logic_axi4_stream_packet_arbiter
  import logic_axi4_stream_packet_arbiter_pkg::*;
#(
  parameter int INPUTS    = 2,
  parameter int WIDTH     = 8,
  parameter int USE_TLAST = 1,
  parameter int TID_WIDTH = $clog2(INPUTS)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [INPUTS-1:0]        rx_tvalid,
  output logic [INPUTS-1:0]        rx_tready,
  input  logic [INPUTS-1:0]        rx_tlast,
  input  logic [INPUTS*WIDTH-1:0]  rx_tdata,
  output logic                     tx_tvalid,
  input  logic                     tx_tready,
  output logic                     tx_tlast,
  output logic [WIDTH-1:0]         tx_tdata,
  output logic [TID_WIDTH-1:0]     tx_tid
);

  localparam int PW = $clog2(INPUTS);

  state_t            state;
  logic [PW-1:0]     pointer;
  logic [PW-1:0]     owner;

  logic [INPUTS-1:0] arb_grant;
  logic [PW-1:0]     arb_idx;
  logic [INPUTS-1:0] grant;
  logic [PW-1:0]     sel;
  logic              load;
  logic              hs;
  logic              sel_last;
  logic              beat_last;
  logic [WIDTH-1:0]  sel_data;

  logic_round_robin_arbiter #(.N(INPUTS), .IW(PW)) u_rr (
    .req     (rx_tvalid),
    .pointer (pointer),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  always_comb begin
    // output register can take a beat when empty or draining this cycle
    load = !tx_tvalid || tx_tready;
    sel  = (state == LOCKED) ? owner : arb_idx;
    // while locked the owner keeps the grant even if it stalls its tvalid
    for (int i = 0; i < INPUTS; i++) begin
      grant[i] = (state == LOCKED) ? (owner == PW'(i)) : arb_grant[i];
    end
    rx_tready = grant & {INPUTS{load}};
    hs        = |(rx_tready & rx_tvalid);
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (sel == PW'(i)) begin
        sel_data = rx_tdata[i*WIDTH +: WIDTH];
        sel_last = rx_tlast[i];
      end
    end
    // without tlast every beat is its own packet
    beat_last = (USE_TLAST == 0) ? 1'b1 : sel_last;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      pointer   <= '0;
      owner     <= '0;
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_tdata  <= '0;
      tx_tid    <= '0;
    end else begin
      if (load) begin
        tx_tvalid <= hs;
        if (hs) begin
          tx_tdata <= sel_data;
          tx_tlast <= beat_last;
          tx_tid   <= TID_WIDTH'(sel);
        end
      end
      if (hs) begin
        if (beat_last) begin
          state   <= IDLE;
          pointer <= (sel == PW'(INPUTS-1)) ? '0 : sel + 1'b1;
        end else begin
          state <= LOCKED;
          owner <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
module tb_logic_axi4_stream_packet_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           aclk = 1'b0;
  logic           areset;
  logic [N-1:0]   rx_tvalid, rx_tready, rx_tlast;
  logic [N*W-1:0] rx_tdata;
  logic           tx_tvalid, tx_tready, tx_tlast;
  logic [W-1:0]   tx_tdata;
  logic [1:0]     tx_tid;

  int n_chk  = 0;
  int n_fail = 0;

  // per-source beat queues: data, last, idle cycles before presenting
  logic [7:0]  dq[N][$];
  bit          lq[N][$];
  int          gq[N][$];
  int          wcnt[N];
  // per-source expected beats {last, tid, data}; moved to exp_q in service order
  logic [31:0] src_exp[N][$];
  logic [31:0] exp_q[$];

  logic_axi4_stream_packet_arbiter #(
    .INPUTS(N), .WIDTH(W), .USE_TLAST(1), .TID_WIDTH(2)
  ) dut (
    .aclk(aclk), .areset(areset),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata),
    .tx_tid(tx_tid)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int nb, input int gap1);
    logic [7:0] d;
    int g;
    for (int b = 0; b < nb; b++) begin
      d = 8'($urandom_range(0, 255));
      g = (b == 1) ? gap1 : 0;
      if (dq[s].size() == 0) wcnt[s] = g;
      dq[s].push_back(d);
      lq[s].push_back(b == nb - 1);
      gq[s].push_back(g);
      src_exp[s].push_back(32'({(b == nb - 1), 2'(s), d}));
    end
  endtask

  task automatic exp_next(input int s);
    logic [31:0] e;
    for (int k = 0; k < 64; k++) begin
      if (src_exp[s].size() == 0) break;
      e = src_exp[s].pop_front();
      exp_q.push_back(e);
      if (e[10]) break;
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    bit empty;
    for (k = 0; k < 500; k++) begin
      @(negedge aclk);
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (dq[i].size() != 0) empty = 1'b0;
      if (empty && exp_q.size() == 0 && tx_tvalid !== 1'b1) break;
    end
    chk(tag, 32'(k < 500), 32'd1);
  endtask

  task automatic wait_tx(input string tag);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (tx_tvalid === 1'b1) break;
    end
    chk(tag, 32'(k < 50), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0]  tv;
    logic [31:0] exp_b1;
    int          cnt;

    areset    = 1'b1;
    tx_tready = 1'b1;
    rx_tvalid = '0;
    rx_tlast  = '0;
    rx_tdata  = '0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;

    // source driver and output scoreboard
    fork
      begin
        logic [N-1:0] acc;
        logic [31:0]  act, e;
        forever begin
          @(negedge aclk);
          acc = rx_tvalid & rx_tready;
          if (tx_tvalid === 1'b1 && tx_tready) begin
            act = 32'({tx_tlast, tx_tid, tx_tdata});
            if (exp_q.size() == 0) chk("sb_extra", act, 32'hffff_ffff);
            else begin
              e = exp_q.pop_front();
              chk("sb_beat", act, e);
            end
          end
          @(posedge aclk);
          #1;
          for (int i = 0; i < N; i++) begin
            if (acc[i] === 1'b1 && dq[i].size() > 0) begin
              dq[i].delete(0);
              lq[i].delete(0);
              gq[i].delete(0);
              wcnt[i] = (gq[i].size() > 0) ? gq[i][0] : 0;
            end
            if (dq[i].size() > 0 && wcnt[i] > 0) begin
              wcnt[i]--;
              rx_tvalid[i] = 1'b0;
            end else if (dq[i].size() > 0) begin
              rx_tvalid[i]         = 1'b1;
              rx_tdata[i*W +: W]   = dq[i][0];
              rx_tlast[i]          = lq[i][0];
            end else begin
              rx_tvalid[i] = 1'b0;
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_out", 32'({tx_tvalid, tx_tlast, tx_tid, tx_tdata}), 32'd0);
    chk("rst_rdy", 32'(rx_tready), 32'd0);

    // all idle
    repeat (5) begin
      @(negedge aclk);
      chk("idle", 32'({rx_tready, tx_tvalid}), 32'd0);
    end

    // single requester, 3-beat packet, latency 1
    push_pkt(2, 3, 0);
    exp_next(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      tv[k] = tx_tvalid;
      if (k == 0) chk("t2_rdy", 32'(rx_tready), 32'b0100);
    end
    chk("t2_lat", 32'(tv), 32'b01110);
    wait_done("t2_done");

    // pointer now 3: req3 beats req0, then wrap
    push_pkt(0, 1, 0);
    push_pkt(3, 1, 0);
    exp_next(3);
    exp_next(0);
    wait_done("t2b_done");
    push_pkt(3, 1, 0);
    exp_next(3);
    wait_done("t2c_done");

    // all four, two 2-beat packets each, pointer 0: full throughput
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) push_pkt(s, 2, 0);
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) exp_next(s);
    wait_tx("t3_start");
    cnt = 1;
    repeat (15) begin
      @(negedge aclk);
      if (tx_tvalid === 1'b1) cnt++;
    end
    chk("t3_nobubble", 32'(cnt), 32'd16);
    wait_done("t3_done");

    // owner stalls mid-packet; req1 must wait
    push_pkt(0, 2, 5);
    push_pkt(1, 1, 0);
    exp_next(0);
    exp_next(1);
    @(negedge aclk);
    repeat (5) begin
      @(negedge aclk);
      chk("t4_lock", 32'(rx_tready), 32'b0001);
    end
    wait_done("t4_done");

    // downstream stall mid-packet
    push_pkt(1, 3, 0);
    exp_next(1);
    exp_b1 = exp_q[1];
    wait_tx("t5_start");
    @(posedge aclk);
    #1 tx_tready = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      chk("t5_hold", 32'({tx_tvalid, tx_tlast, tx_tid, tx_tdata}), 32'({1'b1, exp_b1[10:0]}));
      chk("t5_rdy", 32'(rx_tready), 32'd0);
    end
    @(posedge aclk);
    #1 tx_tready = 1'b1;
    wait_done("t5_done");

    // reset while locked with an output beat pending
    push_pkt(2, 3, 0);
    exp_next(2);
    wait_tx("t6_start");
    @(posedge aclk);
    #1;
    areset    = 1'b1;
    tx_tready = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      lq[i].delete();
      gq[i].delete();
      src_exp[i].delete();
      wcnt[i] = 0;
    end
    rx_tvalid = '0;
    exp_q.delete();
    @(posedge aclk);
    #1;
    areset    = 1'b0;
    tx_tready = 1'b1;
    @(negedge aclk);
    chk("t6_txv", 32'({tx_tvalid, tx_tid}), 32'd0);
    chk("t6_rdy", 32'(rx_tready), 32'd0);
    // pointer back at 0: req1 before req3
    push_pkt(3, 1, 0);
    push_pkt(1, 1, 0);
    exp_next(1);
    exp_next(3);
    wait_done("t6_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
